// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sampler.
// The state encoding, channel count and select width live here so that the
// sampler and any future checker agree on them.
package mux_scan_pkg;

    // Number of channels behind the downstream mux and the select width.
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    // Channel select as driven to the mux.
    typedef logic [SEL_W-1:0] sel_t;

    // Last channel of a scan; its capture ends the scan.
    localparam sel_t LAST_CH = sel_t'(NUM_CH - 1);

    // Scan FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    // Even parity of an assembled word (XOR of all bits).
    function automatic logic word_parity(input logic [NUM_CH-1:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter for the mux scan sampler.
// Counts the cycles a channel select has been held. done is high while the
// count sits at DWELL-1; an enabled cycle with done high wraps the count to 0
// so the next channel starts its dwell from zero.
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    // A single-cycle dwell still needs a one-bit register to stay legal.
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next count: clear wins, otherwise advance and wrap at the dwell end.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clr) begin
            cnt_nxt_s = CNT_W'(0);
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_nxt_s = CNT_W'(0);
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_W'(0);
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign done = (cnt_r == CNT_LAST);

endmodule

// File: rtl/mux_scan_sampler.sv
// Mux scan sampler: steps a 2-bit select through the four channels of an
// external 4:1 mux, holds each select for DWELL cycles, captures the mux
// output at the end of each dwell and presents the assembled 4-bit word with
// a valid/ready handshake. In continuous mode a new scan starts as soon as a
// word is accepted.
// Optional build macro MUX_SCAN_PARITY_EN adds output word_par, the XOR of
// word, registered alongside word.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              mux_out,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] word,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              word_par
`endif
);

    // A zero dwell would capture before the select has been driven at all.
    generate
        if (DWELL < 1) begin : g_dwell_check
            $error("mux_scan_sampler: DWELL must be at least 1");
        end
    endgenerate

    state_e            state_r;
    state_e            state_nxt_s;
    sel_t              sel_r;
    sel_t              sel_nxt_s;
    logic [NUM_CH-1:0] word_r;
    logic [NUM_CH-1:0] word_nxt_s;
    logic              valid_r;
    logic              valid_nxt_s;
    logic              busy_r;
    logic              busy_nxt_s;
    logic              dwell_done_s;
    logic              cnt_clr_s;
    logic              cnt_en_s;

    // The dwell counter only runs while settling and is held at zero otherwise,
    // so every scan starts its first dwell from a clean count.
    assign cnt_en_s  = (state_r == ST_SETTLE);
    assign cnt_clr_s = (state_r != ST_SETTLE);

    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr_s),
        .en   (cnt_en_s),
        .done (dwell_done_s)
    );

    // Next-state, select and capture decode for the scan FSM.
    always_comb begin
        state_nxt_s = state_r;
        sel_nxt_s   = sel_r;
        word_nxt_s  = word_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                    sel_nxt_s   = sel_t'(0);
                end else begin
                    state_nxt_s = ST_IDLE;
                    sel_nxt_s   = sel_t'(0);
                end
            end
            ST_SETTLE: begin
                if (dwell_done_s) begin
                    // Only the bit of the current channel is replaced; the
                    // others keep their value from the previous scan.
                    word_nxt_s[sel_r] = mux_out;
                    sel_nxt_s         = sel_r + sel_t'(1);
                    if (sel_r == LAST_CH) begin
                        state_nxt_s = ST_OUT;
                    end else begin
                        state_nxt_s = ST_SETTLE;
                    end
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_OUT: begin
                // start is deliberately not looked at here.
                if (word_ready) begin
                    sel_nxt_s = sel_t'(0);
                    if (continuous) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                sel_nxt_s   = sel_t'(0);
            end
        endcase
        valid_nxt_s = (state_nxt_s == ST_OUT);
        busy_nxt_s  = (state_nxt_s != ST_IDLE);
    end

    // State and output registers; reset overrides everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sel_r   <= sel_t'(0);
            word_r  <= NUM_CH'(0);
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sel_r   <= sel_nxt_s;
            word_r  <= word_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign sel        = sel_r;
    assign word       = word_r;
    assign word_valid = valid_r;
    assign busy       = busy_r;

`ifdef MUX_SCAN_PARITY_EN
    logic par_r;

    // Parity register updated from the same next value as word.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_r <= 1'b0;
        end else begin
            par_r <= word_parity(word_nxt_s);
        end
    end

    assign word_par = par_r;
`endif

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: a DWELL=2 instance exercised with directed and
// randomized scans (expected words queued at scan start, compared by a
// handshake monitor), and a DWELL=1 instance for single-cycle dwell timing.
module tb_mux_scan_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // DWELL=2 instance
    logic       a_rst, a_start, a_cont, a_ready, a_valid, a_busy, a_mux;
    logic [3:0] a_in, a_word;
    logic [1:0] a_sel;
    // DWELL=1 instance
    logic       b_rst, b_start, b_cont, b_ready, b_valid, b_busy, b_mux;
    logic [3:0] b_in, b_word;
    logic [1:0] b_sel;
`ifdef MUX_SCAN_PARITY_EN
    logic       a_par, b_par;
`endif

    // Model of the external 4:1 mux.
    assign a_mux = a_in[a_sel];
    assign b_mux = b_in[b_sel];

    mux_scan_sampler #(.DWELL(2)) u_a (
        .clk(clk), .rst(a_rst), .start(a_start), .continuous(a_cont),
        .mux_out(a_mux), .sel(a_sel), .word(a_word), .word_valid(a_valid),
        .word_ready(a_ready), .busy(a_busy)
`ifdef MUX_SCAN_PARITY_EN
        , .word_par(a_par)
`endif
    );

    mux_scan_sampler #(.DWELL(1)) u_b (
        .clk(clk), .rst(b_rst), .start(b_start), .continuous(b_cont),
        .mux_out(b_mux), .sel(b_sel), .word(b_word), .word_valid(b_valid),
        .word_ready(b_ready), .busy(b_busy)
`ifdef MUX_SCAN_PARITY_EN
        , .word_par(b_par)
`endif
    );

    // Expected words, one per scan, in the order they should be accepted.
    logic [3:0] exp_q[$];
    logic [3:0] sb_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (a_rst === 1'b0 && a_valid === 1'b1 && a_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra_word: got %0h want none at %0t", a_word, $time);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_word", {28'd0, a_word}, {28'd0, sb_exp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for word_valid on the DWELL=2 instance, optionally
    // toggling start at random while the scan is running.
    task automatic wait_a_valid(input string name, input int limit, input bit rnd_start);
        int n = 0;
        while (a_valid !== 1'b1 && n < limit) begin
            if (rnd_start) a_start = ($urandom_range(0, 1) != 0);
            step();
            n++;
        end
        if (a_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s: got no word_valid want word_valid within %0d cycles", name, limit);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int nsc;
        int d;
        logic [3:0] held;

        a_rst = 1'b1; a_start = 1'b0; a_cont = 1'b0; a_ready = 1'b0; a_in = 4'd0;
        b_rst = 1'b1; b_start = 1'b0; b_cont = 1'b0; b_ready = 1'b0; b_in = 4'd0;
        step();
        step();
        chk("rst_sel", a_sel, 0);
        chk("rst_word", a_word, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
`ifdef MUX_SCAN_PARITY_EN
        chk("rst_par", a_par, 0);
`endif
        a_rst = 1'b0;
        step();

        // First scan: select sequence, latency and captured word.
        a_in = 4'b1010;
        a_start = 1'b1;
        exp_q.push_back(4'b1010);
        step();
        a_start = 1'b0;
        for (int c = 1; c <= 4 * 2; c++) begin
            chk("scan_sel", a_sel, (c - 1) / 2);
            chk("scan_busy", a_busy, 1);
            chk("scan_valid_low", a_valid, 0);
            step();
        end
        chk("first_valid", a_valid, 1);
        chk("first_word", a_word, 4'b1010);
        chk("first_busy", a_busy, 1);
`ifdef MUX_SCAN_PARITY_EN
        chk("par_1010", a_par, 0);
`endif

        // Backpressure: word and valid hold while ready is low.
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_word", a_word, 4'b1010);
            chk("hold_valid", a_valid, 1);
        end
        a_ready = 1'b1;
        a_cont = 1'b0;
        step();
        a_ready = 1'b0;
        chk("done_busy", a_busy, 0);
        chk("done_valid", a_valid, 0);
        chk("done_sel", a_sel, 0);
        chk("idle_word_kept", a_word, 4'b1010);

        // Continuous mode: second scan starts right after the handshake.
        a_cont = 1'b1;
        a_start = 1'b1;
        exp_q.push_back(4'b1010);
        step();
        a_start = 1'b0;
        wait_a_valid("cont_wait1", 12, 1'b0);
        a_in = 4'b1000;
        exp_q.push_back(4'b1000);
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        a_cont = 1'b0;
        chk("cont_sel0", a_sel, 0);
        chk("cont_busy", a_busy, 1);
        chk("cont_valid_low", a_valid, 0);
        wait_a_valid("cont_wait2", 12, 1'b0);
        chk("cont_word", a_word, 4'b1000);
`ifdef MUX_SCAN_PARITY_EN
        chk("par_1000", a_par, 1);
`endif
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        chk("cont_end_busy", a_busy, 0);

        // Reset in the middle of a scan, with start held high during reset.
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        n = 0;
        while (a_sel !== 2'd2 && n < 20) begin
            step();
            n++;
        end
        chk("reach_sel2", a_sel, 2);
        a_rst = 1'b1;
        a_start = 1'b1;
        step();
        a_rst = 1'b0;
        a_start = 1'b0;
        chk("mid_rst_sel", a_sel, 0);
        chk("mid_rst_word", a_word, 0);
        chk("mid_rst_valid", a_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
`ifdef MUX_SCAN_PARITY_EN
        chk("mid_rst_par", a_par, 0);
`endif
        step();
        chk("no_scan_after_rst", a_busy, 0);
        step();
        chk("no_scan_after_rst2", a_busy, 0);

        // Randomized scans: random words, random backpressure, random chains
        // of continuous scans and stray start pulses while busy.
        for (int it = 0; it < 25; it++) begin
            nsc = $urandom_range(1, 3);
            a_in = 4'($urandom_range(0, 15));
            exp_q.push_back(a_in);
            a_start = 1'b1;
            step();
            for (int s = 0; s < nsc; s++) begin
                a_cont = (s < nsc - 1);
                wait_a_valid("rnd_wait", 12, 1'b1);
                held = a_word;
                d = $urandom_range(0, 3);
                for (int k = 0; k < d; k++) begin
                    a_start = ($urandom_range(0, 1) != 0);
                    step();
                    chk("rnd_hold_valid", a_valid, 1);
                    chk("rnd_hold_word", a_word, held);
                end
                a_start = ($urandom_range(0, 1) != 0);
                a_ready = 1'b1;
                if (s < nsc - 1) begin
                    a_in = 4'($urandom_range(0, 15));
                    exp_q.push_back(a_in);
                end
                step();
                a_ready = 1'b0;
                a_start = 1'b0;
            end
            chk("rnd_idle_busy", a_busy, 0);
            step();
        end
        a_cont = 1'b0;
        chk("sb_drained", exp_q.size(), 0);

        // DWELL=1: one cycle per channel, extra start during the scan ignored.
        b_rst = 1'b0;
        b_in = 4'b0110;
        step();
        b_start = 1'b1;
        step();
        for (int c = 1; c <= 4; c++) begin
            b_start = (c == 2);
            chk("d1_sel", b_sel, c - 1);
            chk("d1_valid_low", b_valid, 0);
            chk("d1_busy", b_busy, 1);
            step();
        end
        b_start = 1'b0;
        chk("d1_valid", b_valid, 1);
        chk("d1_word", b_word, 4'b0110);
`ifdef MUX_SCAN_PARITY_EN
        chk("d1_par", b_par, 0);
`endif
        b_ready = 1'b1;
        step();
        b_ready = 1'b0;
        chk("d1_done_busy", b_busy, 0);
        chk("d1_done_valid", b_valid, 0);
        step();
        chk("d1_no_extra_scan", b_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_scan_sampler.md
MUX_SCAN_SAMPLER -- requirements
Module: mux_scan_sampler

Interface
REQ-001 The block SHALL have parameter DWELL, default 2: clock cycles `sel` is held per channel before `mux_out` is captured.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request one scan; sampled only in IDLE.
REQ-005 The block SHALL have port continuous, input, 1 bit: when 1, a new scan restarts after each accepted word.
REQ-006 The block SHALL have port mux_out, input, 1 bit: the selected bit returned by the downstream 4:1 mux.
REQ-007 The block SHALL have port sel, output, 2 bits: channel select driven to the 4:1 mux.
REQ-008 The block SHALL have port word, output, 4 bits: the assembled sample, where word[k] is mux_out captured while sel==k.
REQ-009 The block SHALL have port word_valid, output, 1 bit: word is available.
REQ-010 The block SHALL have port word_ready, input, 1 bit: the consumer accepts the word.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, SETTLE and OUT, all registered.
REQ-013 IDLE with start=1 SHALL transition to SETTLE with sel=0 and the dwell count at 0; otherwise the FSM stays in IDLE.
REQ-014 In SETTLE, each cycle SHALL increment the dwell count; when count==DWELL-1 the block SHALL capture word[sel]<=mux_out, clear the count and set sel<=sel+1 (mod 4).
REQ-015 The capture of channel 3 SHALL transition SETTLE to OUT, with sel wrapping to 0.
REQ-016 word_valid SHALL be high in every OUT cycle and low in all other states.
REQ-017 While word_valid=1 and word_ready=0, word SHALL remain stable.
REQ-018 In OUT with word_ready=1, the FSM SHALL go to SETTLE (sel=0) if continuous=1, otherwise to IDLE.
REQ-019 With start accepted at edge 0, word_valid SHALL first be high in cycle 4*DWELL+1.
REQ-020 start SHALL be ignored in SETTLE and OUT, including when start and word_ready are both high in OUT.
REQ-021 word SHALL retain its last value in IDLE; it SHALL NOT be cleared between scans, only overwritten bit-by-bit.
REQ-022 DWELL<1 SHALL be rejected at elaboration.

Reset
REQ-023 rst=1 at a clock edge SHALL force state=IDLE, sel=0, dwell count=0, word=0, word_valid=0 and busy=0, from any state including mid-scan.
REQ-024 start SHALL be ignored in any cycle where rst=1.

Configuration
REQ-025 With MUX_SCAN_PARITY_EN defined, the block SHALL add output word_par (1 bit), defined as the XOR of word, registered with the same timing as word, and reset to 0.
REQ-026 Without MUX_SCAN_PARITY_EN, word_par and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package mux_scan_pkg SHALL hold the state enum typedef, the constants NUM_CH=4 and SEL_W=2, and the sel typedef.
REQ-028 Sub-module mux_scan_dwell_cnt SHALL implement the parameterised dwell counter, with inputs clk, rst, clr and en and output done (count==DWELL-1).

Verification
REQ-029 With DWELL=2, mux in=4'b1010 and a start pulse at edge 0, the bench SHALL check that sel reads 0,0,1,1,2,2,3,3 over cycles 1-8, that word_valid=1 in cycle 9 with word=4'b1010, and that busy=1 in cycles 1-9.
REQ-030 With word_ready held low for 5 cycles in OUT, the bench SHALL check that word and word_valid are stable; on word_ready=1 with continuous=0, the next cycle SHALL show IDLE with busy=0 and word_valid=0.
REQ-031 With continuous=1 and in changed to 4'b1000 before the second scan, the bench SHALL check that sel returns to 0 the cycle after the handshake and that the second word=4'b1000.
REQ-032 With rst pulsed while in SETTLE at sel=2 and start high during the reset, the bench SHALL check that the next cycle shows sel=0, word=0, word_valid=0 and busy=0, and that no scan starts.
REQ-033 With DWELL=1 and start re-pulsed during SETTLE, the bench SHALL check that word_valid rises in cycle 5 and that the extra start has no effect.
REQ-034 With MUX_SCAN_PARITY_EN defined, the bench SHALL check that word=4'b1010 gives word_par=0 and word=4'b1000 gives word_par=1.
